// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and default sizing for the interrupt entry / RTI sequencer.
// The PC is always stacked as two data words, so the PC width is twice the data width.
package intr_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_PC_W    = 2 * DEFAULT_DATA_W;
    localparam int DEFAULT_FLAGS_W = 4;

    // Address of the vector's high word; the low word follows it.
    localparam logic [DEFAULT_PC_W-1:0] DEFAULT_VECTOR_ADDR = '0;

    typedef enum logic [3:0] {
        IDLE,
        I_PUSH_HI,
        I_PUSH_LO,
        I_PUSH_FLG,
        I_VEC_HI,
        I_VEC_LO,
        R_POP_FLG,
        R_POP_LO,
        R_POP_HI
    } state_t;

endpackage

// File: rtl/interrupt_sequencer.sv
// Hardware interrupt-entry and RTI sequencer: stacks/unstacks PC and CCR through the
// data-memory port and loads the PC from the vector, stalling the pipeline while busy.
module interrupt_sequencer
    import intr_pkg::*;
#(
    parameter int                PC_W        = DEFAULT_PC_W,
    parameter int                DATA_W      = DEFAULT_DATA_W,
    parameter int                FLAGS_W     = DEFAULT_FLAGS_W,
    parameter logic [PC_W-1:0]   VECTOR_ADDR = DEFAULT_VECTOR_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               intr_req,
    input  logic               rti,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic [PC_W-1:0]    sp_in,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               busy,
    output logic               flush,
    output logic               mem_we,
    output logic               mem_re,
    output logic [PC_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               sp_we,
    output logic [PC_W-1:0]    sp_out,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_out,
    output logic               flags_load,
    output logic [FLAGS_W-1:0] flags_out
);

    localparam logic [PC_W-1:0] OFF_1 = PC_W'(1);
    localparam logic [PC_W-1:0] OFF_2 = PC_W'(2);
    localparam logic [PC_W-1:0] OFF_3 = PC_W'(3);

    state_t state;
    state_t state_next;
    state_t cur_state;

    logic               accept_rti;
    logic               accept_intr;
    logic               pending;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    sp_r;
    logic [FLAGS_W-1:0] flags_r;
    logic [DATA_W-1:0]  word_r;

    logic [PC_W-1:0]    pc_base;
    logic [PC_W-1:0]    sp_base;
    logic [FLAGS_W-1:0] flags_base;

    // The acceptance cycle already performs the first step, so it works from the live inputs.
    assign pc_base    = (state == IDLE) ? pc_in    : pc_r;
    assign sp_base    = (state == IDLE) ? sp_in    : sp_r;
    assign flags_base = (state == IDLE) ? flags_in : flags_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        accept_rti  = 1'b0;
        accept_intr = 1'b0;
        cur_state   = state;
        if (state == IDLE && !reset) begin
            if (rti) begin
                accept_rti = 1'b1;
                cur_state  = R_POP_FLG;
            end else if (intr_req || pending) begin
                accept_intr = 1'b1;
                cur_state   = I_PUSH_HI;
            end
        end

        case (cur_state)
            I_PUSH_HI:  state_next = I_PUSH_LO;
            I_PUSH_LO:  state_next = I_PUSH_FLG;
            I_PUSH_FLG: state_next = I_VEC_HI;
            I_VEC_HI:   state_next = I_VEC_LO;
            R_POP_FLG:  state_next = R_POP_LO;
            R_POP_LO:   state_next = R_POP_HI;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        flush      = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sp_we      = 1'b0;
        sp_out     = '0;
        pc_load    = 1'b0;
        pc_out     = '0;
        flags_load = 1'b0;
        flags_out  = '0;

        case (cur_state)
            I_PUSH_HI: begin
                busy      = 1'b1;
                flush     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_base;
                mem_wdata = pc_base[PC_W-1:DATA_W];
                sp_we     = 1'b1;
                sp_out    = sp_base - OFF_1;
            end
            I_PUSH_LO: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_base - OFF_1;
                mem_wdata = pc_base[DATA_W-1:0];
                sp_we     = 1'b1;
                sp_out    = sp_base - OFF_2;
            end
            I_PUSH_FLG: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_base - OFF_2;
                mem_wdata = {{(DATA_W-FLAGS_W){1'b0}}, flags_base};
                sp_we     = 1'b1;
                sp_out    = sp_base - OFF_3;
            end
            I_VEC_HI: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = VECTOR_ADDR;
            end
            I_VEC_LO: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = VECTOR_ADDR + OFF_1;
                pc_load  = 1'b1;
                pc_out   = {word_r, mem_rdata};
            end
            R_POP_FLG: begin
                busy       = 1'b1;
                mem_re     = 1'b1;
                mem_addr   = sp_base + OFF_1;
                flags_load = 1'b1;
                flags_out  = mem_rdata[FLAGS_W-1:0];
                sp_we      = 1'b1;
                sp_out     = sp_base + OFF_1;
            end
            R_POP_LO: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = sp_base + OFF_2;
                sp_we    = 1'b1;
                sp_out   = sp_base + OFF_2;
            end
            R_POP_HI: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = sp_base + OFF_3;
                pc_load  = 1'b1;
                pc_out   = {mem_rdata, word_r};
                sp_we    = 1'b1;
                sp_out   = sp_base + OFF_3;
            end
            default: ;
        endcase
    end

    // A request that cannot start now is remembered once; it fires from IDLE after the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            pc_r    <= '0;
            sp_r    <= '0;
            flags_r <= '0;
            word_r  <= '0;
        end else begin
            if (accept_intr) begin
                pending <= 1'b0;
            end else if (intr_req) begin
                pending <= 1'b1;
            end

            if (accept_rti || accept_intr) begin
                pc_r    <= pc_in;
                sp_r    <= sp_in;
                flags_r <= flags_in;
            end

            if (cur_state == I_VEC_HI || cur_state == R_POP_LO) begin
                word_r <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: a transaction-level model predicts stack traffic, PC/CCR loads and busy
// timing per accepted sequence; a negedge monitor compares them against the sequencer.
module tb_interrupt_sequencer;
    import intr_pkg::*;

    localparam int          PC_W    = 32;
    localparam int          DATA_W  = 16;
    localparam int          FLAGS_W = 4;
    localparam logic [31:0] VEC     = 32'h0000_0000;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        intr_req;
    logic        rti;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic [31:0] sp_in;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        flush;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        sp_we;
    logic [31:0] sp_out;
    logic        pc_load;
    logic [31:0] pc_out;
    logic        flags_load;
    logic [3:0]  flags_out;

    interrupt_sequencer #(
        .PC_W        (PC_W),
        .DATA_W      (DATA_W),
        .FLAGS_W     (FLAGS_W),
        .VECTOR_ADDR (VEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .intr_req   (intr_req),
        .rti        (rti),
        .pc_in      (pc_in),
        .flags_in   (flags_in),
        .sp_in      (sp_in),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .flush      (flush),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .sp_we      (sp_we),
        .sp_out     (sp_out),
        .pc_load    (pc_load),
        .pc_out     (pc_out),
        .flags_load (flags_load),
        .flags_out  (flags_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory shared by the model and the asynchronous read port.
    logic [15:0] mem [logic [31:0]];

    always_comb begin
        if (mem.exists(mem_addr)) mem_rdata = mem[mem_addr];
        else                      mem_rdata = 16'h0000;
    end

    // CPU-side architectural registers, updated from the sequencer's strobes.
    logic [31:0] env_pc;
    logic [31:0] env_sp;
    logic [3:0]  env_flags;
    logic        set_arch;
    logic [31:0] set_pc;
    logic [31:0] set_sp;
    logic [3:0]  set_flags;

    assign pc_in    = env_pc;
    assign sp_in    = env_sp;
    assign flags_in = env_flags;

    always @(posedge clk) begin
        if (set_arch) begin
            env_pc    <= set_pc;
            env_sp    <= set_sp;
            env_flags <= set_flags;
        end else if (!reset) begin
            if (sp_we)      env_sp    <= sp_out;
            if (pc_load)    env_pc    <= pc_out;
            if (flags_load) env_flags <= flags_out;
        end
    end

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_sp;
    logic [3:0]  m_flags;
    int          busy_left;
    bit          pend;

    wr_t exp_wr[$];
    ev_t exp_sp[$];
    ev_t exp_pc[$];
    ev_t exp_flg[$];
    ev_t exp_busy[$];
    ev_t exp_flush[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [15:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic start_intr();
        logic [15:0] w [3];
        w[0] = m_pc[31:16];
        w[1] = m_pc[15:0];
        w[2] = {12'h000, m_flags};
        exp_flush.push_back('{cyc, 32'h1});
        for (int k = 0; k < 3; k++) begin
            exp_wr.push_back('{cyc + k, m_sp - 32'(k), w[k]});
            mem[m_sp - 32'(k)] = w[k];
            exp_sp.push_back('{cyc + k, m_sp - 32'(k + 1)});
        end
        m_sp = m_sp - 32'd3;
        m_pc = {rd(VEC), rd(VEC + 32'd1)};
        exp_pc.push_back('{cyc + 4, m_pc});
        busy_left = 4;
    endtask

    task automatic start_rti();
        logic [15:0] f;
        logic [15:0] lo;
        logic [15:0] hi;
        f  = rd(m_sp + 32'd1);
        lo = rd(m_sp + 32'd2);
        hi = rd(m_sp + 32'd3);
        m_flags = f[3:0];
        exp_flg.push_back('{cyc, {28'h0, m_flags}});
        for (int k = 0; k < 3; k++) exp_sp.push_back('{cyc + k, m_sp + 32'(k + 1)});
        m_pc = {hi, lo};
        exp_pc.push_back('{cyc + 2, m_pc});
        m_sp = m_sp + 32'd3;
        busy_left = 2;
    endtask

    // Drives one cycle of requests, predicts its outcome, and advances to the next cycle.
    task automatic applyStimulus(input bit i, input bit r);
        bit acc;
        bit was_busy;
        intr_req = i;
        rti      = r;
        acc      = 1'b0;
        was_busy = (busy_left > 0);
        if (!was_busy) begin
            if (r) begin
                start_rti();
                acc = 1'b1;
                if (i) pend = 1'b1;
            end else if (i || pend) begin
                start_intr();
                acc  = 1'b1;
                pend = 1'b0;
            end
        end else begin
            busy_left--;
            if (i) pend = 1'b1;
        end
        exp_busy.push_back('{cyc, {31'h0, acc | was_busy}});
        @(posedge clk);
        #1;
        intr_req = 1'b0;
        rti      = 1'b0;
    endtask

    task automatic setArch(input logic [31:0] pc, input logic [31:0] sp, input logic [3:0] fl);
        m_pc      = pc;
        m_sp      = sp;
        m_flags   = fl;
        set_pc    = pc;
        set_sp    = sp;
        set_flags = fl;
        set_arch  = 1'b1;
        applyStimulus(1'b0, 1'b0);
        set_arch  = 1'b0;
    endtask

    task automatic purge_from(input int c);
        for (int k = exp_wr.size() - 1; k >= 0; k--)    if (exp_wr[k].cyc >= c)    exp_wr.delete(k);
        for (int k = exp_sp.size() - 1; k >= 0; k--)    if (exp_sp[k].cyc >= c)    exp_sp.delete(k);
        for (int k = exp_pc.size() - 1; k >= 0; k--)    if (exp_pc[k].cyc >= c)    exp_pc.delete(k);
        for (int k = exp_flg.size() - 1; k >= 0; k--)   if (exp_flg[k].cyc >= c)   exp_flg.delete(k);
        for (int k = exp_busy.size() - 1; k >= 0; k--)  if (exp_busy[k].cyc >= c)  exp_busy.delete(k);
        for (int k = exp_flush.size() - 1; k >= 0; k--) if (exp_flush[k].cyc >= c) exp_flush.delete(k);
    endtask

    // Monitor: every cycle each strobe either matches the head of its queue or must be low.
    always @(negedge clk) begin
        ev_t e;
        wr_t w;
        if (reset) begin
            checkOutput("reset_outputs",
                {20'h0, busy, flush, mem_we, mem_re, sp_we, pc_load, flags_load,
                 |mem_addr, |mem_wdata, |sp_out, |pc_out, |flags_out}, 32'h0);
        end else begin
            if (exp_busy.size() > 0 && exp_busy[0].cyc == cyc) begin
                e = exp_busy.pop_front();
                checkOutput("busy", {31'h0, busy}, e.val);
            end else begin
                checkOutput("busy_idle", {31'h0, busy}, 32'h0);
            end

            if (exp_flush.size() > 0 && exp_flush[0].cyc == cyc) begin
                e = exp_flush.pop_front();
                checkOutput("flush", {31'h0, flush}, e.val);
            end else begin
                checkOutput("flush_idle", {31'h0, flush}, 32'h0);
            end

            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                w = exp_wr.pop_front();
                checkOutput("mem_we", {31'h0, mem_we}, 32'h1);
                checkOutput("wr_addr", mem_addr, w.addr);
                checkOutput("wr_data", {16'h0, mem_wdata}, {16'h0, w.data});
            end else begin
                checkOutput("mem_we_idle", {31'h0, mem_we}, 32'h0);
            end

            if (exp_sp.size() > 0 && exp_sp[0].cyc == cyc) begin
                e = exp_sp.pop_front();
                checkOutput("sp_we", {31'h0, sp_we}, 32'h1);
                checkOutput("sp_out", sp_out, e.val);
            end else begin
                checkOutput("sp_we_idle", {31'h0, sp_we}, 32'h0);
            end

            if (exp_pc.size() > 0 && exp_pc[0].cyc == cyc) begin
                e = exp_pc.pop_front();
                checkOutput("pc_load", {31'h0, pc_load}, 32'h1);
                checkOutput("pc_out", pc_out, e.val);
            end else begin
                checkOutput("pc_load_idle", {31'h0, pc_load}, 32'h0);
            end

            if (exp_flg.size() > 0 && exp_flg[0].cyc == cyc) begin
                e = exp_flg.pop_front();
                checkOutput("flags_load", {31'h0, flags_load}, 32'h1);
                checkOutput("flags_out", {28'h0, flags_out}, e.val);
            end else begin
                checkOutput("flags_load_idle", {31'h0, flags_load}, 32'h0);
            end

            checkOutput("we_re_exclusive", {31'h0, mem_we & mem_re}, 32'h0);
            checkOutput("pcload_flush_exclusive", {31'h0, pc_load & flush}, 32'h0);
        end
    end

    initial begin
        busy_left = 0;
        pend      = 1'b0;
        reset     = 1'b1;
        intr_req  = 1'b0;
        rti       = 1'b0;
        set_arch  = 1'b1;
        set_pc    = 32'h0;
        set_sp    = 32'h0;
        set_flags = 4'h0;
        m_pc      = 32'h0;
        m_sp      = 32'h0;
        m_flags   = 4'h0;
        mem[VEC]          = 16'h0000;
        mem[VEC + 32'd1]  = 16'h0200;

        // Requests during reset must not reach the outputs.
        @(posedge clk); #1;
        intr_req = 1'b1;
        rti      = 1'b1;
        @(posedge clk); #1;
        intr_req = 1'b0;
        rti      = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        set_arch = 1'b0;

        $display("[TB] interrupt entry");
        setArch(32'h0001_2345, 32'h0000_0FFF, 4'hA);
        applyStimulus(1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("entry_pc", env_pc, 32'h0000_0200);
        checkOutput("entry_sp", env_sp, 32'h0000_0FFC);

        $display("[TB] rti");
        applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("rti_pc", env_pc, 32'h0001_2345);
        checkOutput("rti_flags", {28'h0, env_flags}, 32'hA);
        checkOutput("rti_sp", env_sp, 32'h0000_0FFF);

        $display("[TB] simultaneous rti and intr_req");
        setArch(32'h0000_0000, 32'h0000_0FFC, 4'h0);
        applyStimulus(1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("simul_pc", env_pc, 32'h0000_0200);
        checkOutput("simul_sp", env_sp, 32'h0000_0FFC);

        $display("[TB] merged requests while busy");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (14) applyStimulus(1'b0, 1'b0);
        checkOutput("merge_sp", env_sp, 32'h0000_0FF6);

        $display("[TB] reset during flag push");
        setArch(32'h0000_ABCD, 32'h0000_0800, 4'h5);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        #1;
        reset = 1'b1;
        purge_from(cyc);
        busy_left = 0;
        pend      = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        setArch(32'h0000_ABCD, 32'h0000_0800, 4'h5);
        repeat (8) applyStimulus(1'b0, 1'b0);
        checkOutput("after_reset_sp", env_sp, 32'h0000_0800);

        $display("[TB] stack pointer wrap");
        setArch(32'h0001_2345, 32'h0000_0001, 4'h3);
        applyStimulus(1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("wrap_sp", env_sp, 32'hFFFF_FFFE);

        $display("[TB] randomized traffic");
        mem[VEC]         = 16'h0000;
        mem[VEC + 32'd1] = 16'h0200;
        setArch(32'h0000_1000, 32'h0000_0FFF, 4'h0);
        repeat (400) applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
        repeat (16) applyStimulus(1'b0, 1'b0);

        checkOutput("leftover_expectations",
            32'(exp_wr.size() + exp_sp.size() + exp_pc.size() + exp_flg.size() +
                exp_busy.size() + exp_flush.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Consumes the delayed interrupt pulse (OUT_INTR) produced by the interrupt delayer and executes the hardware interrupt-entry sequence.
- Entry sequence: stall and flush the front end, push the return PC and the CCR flags onto the data-memory stack, then load the PC from the interrupt vector.
- Also runs the reverse sequence for RTI: pop the flags and the PC, then resume.
- Sits beside the memory stage and arbitrates the data-memory port while busy.

Parameters:
- PC_W, 32, PC width. Pushed as two DATA_W halves.
- DATA_W, 16, data-memory word width. PC_W = 2*DATA_W is required.
- FLAGS_W, 4, CCR width (Z,N,C,V).
- VECTOR_ADDR, 0, memory address of the vector's high word. The low word is at VECTOR_ADDR+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- intr_req  in  1  one-cycle interrupt pulse from the delayer.
- rti  in  1  RTI instruction in the memory stage, one-cycle pulse.
- pc_in  in  PC_W  resume PC, sampled on acceptance.
- flags_in  in  FLAGS_W  current CCR, sampled on acceptance.
- sp_in  in  PC_W  current stack pointer, sampled on acceptance.
- mem_rdata  in  DATA_W  asynchronous-read memory data, valid in the same cycle as mem_addr.
- busy  out  1  stall fetch/decode and the memory stage.
- flush  out  1  one-cycle flush of the IF/ID/EX latches.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  PC_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- sp_we  out  1  stack-pointer write strobe.
- sp_out  out  PC_W  new stack-pointer value.
- pc_load  out  1  PC load strobe.
- pc_out  out  PC_W  PC value to load.
- flags_load  out  1  CCR load strobe.
- flags_out  out  FLAGS_W  CCR value to load.

Behaviour:
- Reset:
  - State goes to IDLE; pending bit and all internal registers clear.
  - Every output is 0 while reset is high and on release.
  - Reset mid-sequence aborts immediately; no further memory writes.
- Stack discipline:
  - Push: mem[sp] <= data, then sp <= sp-1.
  - Pop: sp <= sp+1, then data <= mem[sp].
  - SP arithmetic is modulo 2^PC_W; wrap-around is not flagged.
- Acceptance in IDLE:
  - rti has priority over intr_req.
  - On acceptance, capture pc_in, flags_in and sp_in.
  - busy rises combinationally in the acceptance cycle.
  - flush=1 for exactly that cycle, interrupt entry only.
- Interrupt states (one cycle each; busy=1 throughout):
  - I_PUSH_HI: mem_we=1, addr=sp, wdata=pc[31:16]; sp_we=1, sp_out=sp-1.
  - I_PUSH_LO: mem_we=1, addr=sp-1, wdata=pc[15:0]; sp_out=sp-2.
  - I_PUSH_FLG: mem_we=1, addr=sp-2, wdata=zero-extended flags; sp_out=sp-3.
  - I_VEC_HI: mem_re=1, addr=VECTOR_ADDR; latch mem_rdata.
  - I_VEC_LO: mem_re=1, addr=VECTOR_ADDR+1; pc_load=1, pc_out={hi,lo}. Then IDLE.
  - Interrupt latency: 5 cycles from acceptance to pc_load, inclusive.
- RTI states:
  - R_POP_FLG: addr=sp+1; flags_load=1, flags_out=mem_rdata[FLAGS_W-1:0]; sp_out=sp+1.
  - R_POP_LO: addr=sp+2; latch lo; sp_out=sp+2.
  - R_POP_HI: addr=sp+3; pc_load=1, pc_out={mem_rdata,lo}; sp_out=sp+3. Then IDLE.
  - mem_re=1 and sp_we=1 in every pop state.
  - RTI latency: 3 cycles.
- Pending bit:
  - Set by intr_req when the pulse is not accepted: while busy, or in the same cycle as rti.
  - Multiple requests merge into one.
  - Serviced on the cycle after the sequence ends, i.e. it is accepted in IDLE.
  - Cleared on acceptance.
- rti while busy: ignored. The pipeline is stalled, so this is treated as illegal.
- Strobe exclusivity: mem_we and mem_re are never high together. pc_load and flush are never high together.

Decomposition:
- Package intr_pkg: state enum (IDLE, I_PUSH_HI, I_PUSH_LO, I_PUSH_FLG, I_VEC_HI, I_VEC_LO, R_POP_FLG, R_POP_LO, R_POP_HI), DATA_W/PC_W/FLAGS_W defaults, VECTOR_ADDR.
- Single module: FSM plus datapath registers. No sub-module is warranted.

Test Plan:
- Interrupt entry: sp_in=0x0FFF, pc_in=0x00012345, flags=0b1010, mem[0]=0x0000, mem[1]=0x0200, intr_req pulse.
  - Expect flush for 1 cycle.
  - Expect writes: 0x0001@0FFF, 0x2345@0FFE, 0x000A@0FFD.
  - Expect pc_load with 0x00000200 on the 5th cycle; final sp_out=0x0FFC.
- RTI after the above: sp_in=0x0FFC, rti pulse.
  - Expect flags_load 0xA, then pc_load 0x00012345, final sp_out=0x0FFF, 3 busy cycles.
- Simultaneous intr_req and rti in IDLE:
  - Expect the RTI sequence first.
  - Interrupt accepted the cycle after R_POP_HI, pushing the restored PC.
- Two intr_req pulses during I_PUSH_LO and I_VEC_HI:
  - Expect exactly one further entry sequence after the current one.
- Reset asserted in I_PUSH_FLG:
  - All outputs 0 asynchronously; no write at 0x0FFD.
  - Pending bit clear; IDLE after release.
- SP wrap: sp_in=0x00000001, intr_req.
  - Expect writes at 0x1, 0x0, 0xFFFFFFFF; sp_out=0xFFFFFFFE.
